ula_seq_ctrl: RTL

Sequencer that runs W-bit operations (W = 4·NIBBLES) through a single 4-bit 74181-style ALU slice. It processes one nibble per clock, least-significant first, and chains the slice carry between nibbles. It sits between a requester using a start/ready/done handshake and the combinational ALU slice, which it drives through the `alu_*` ports. It accumulates the W-bit result, the final carry and a whole-word equality flag.

---
 rtl/ula_seq_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ula_seq_ctrl.sv
// Nibble-serial sequencer: runs a W-bit operation through one 4-bit 74181-style slice, LSB nibble first.
// Optional macro ULA_SEQ_ABORT_EN adds an abort input that cancels a running operation.
module ula_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef ULA_SEQ_ABORT_EN
   input  logic                 abort,
`endif
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic [3:0]           op_s,
   input  logic                 op_m,
   input  logic                 op_cin,
   output logic                 ready,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 c_out,
   output logic                 a_eq_b,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic [3:0]           alu_s,
   output logic                 alu_m,
   output logic                 alu_cin,
   input  logic [3:0]           alu_f,
   input  logic                 alu_cout,
   input  logic                 alu_aeqb
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q;
   logic [W-1:0]    a_q, b_q, result_q;
   logic [3:0]      s_q;
   logic            m_q, carry_q, eq_q;
   logic            c_out_q, a_eq_b_q;
   logic            abort_hit, last;
   logic [IW+1:0]   shamt;
   logic [W-1:0]    a_sh, b_sh, nib_mask, nib_val;

`ifdef ULA_SEQ_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // Current nibble position drives both the operand select and the result insert.
   assign shamt    = {idx_q, 2'b00};
   assign a_sh     = a_q >> shamt;
   assign b_sh     = b_q >> shamt;
   assign nib_mask = W'(4'hF) << shamt;
   assign nib_val  = W'(alu_f) << shamt;
   assign last     = (idx_q == IW'(NIBBLES - 1));

   assign result = result_q;
   assign c_out  = c_out_q;
   assign a_eq_b = a_eq_b_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      done    = 1'b0;
      alu_a   = 4'h0;
      alu_b   = 4'h0;
      alu_s   = 4'h0;
      alu_m   = 1'b0;
      alu_cin = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            alu_a   = a_sh[3:0];
            alu_b   = b_sh[3:0];
            alu_s   = s_q;
            alu_m   = m_q;
            alu_cin = carry_q;
            if (abort_hit) begin
               state_d = IDLE;
            end else if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latches only matter while in RUN, so they carry no reset.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && start && !rst) begin
         a_q <= op_a;
         b_q <= op_b;
         s_q <= op_s;
         m_q <= op_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         carry_q  <= 1'b0;
         eq_q     <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         a_eq_b_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  idx_q    <= '0;
                  carry_q  <= op_cin;
                  eq_q     <= 1'b1;
                  result_q <= '0;
                  c_out_q  <= 1'b0;
                  a_eq_b_q <= 1'b0;
               end
            end
            RUN: begin
               if (abort_hit) begin
                  idx_q    <= '0;
                  result_q <= '0;
                  c_out_q  <= 1'b0;
                  a_eq_b_q <= 1'b0;
               end else begin
                  result_q <= (result_q & ~nib_mask) | nib_val;
                  carry_q  <= m_q ? 1'b0 : alu_cout;
                  eq_q     <= eq_q & alu_aeqb;
                  idx_q    <= idx_q + 1'b1;
                  // Flags are published on the final nibble so they hold through IDLE.
                  if (last) begin
                     c_out_q  <= m_q ? 1'b0 : alu_cout;
                     a_eq_b_q <= eq_q & alu_aeqb;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
